// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the sequential-arithmetic datapaths.
//   state_t       : control states of the bit-serial units (IDLE/SHIFT/DONE)
//   SUB_WIDTH_MAX : widest operand the serial subtractor is meant to handle
// No ports; imported with `import arith_pkg::*;`.
// ---------------------------------------------------------------------------
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int SUB_WIDTH_MAX = 32;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// Combinational 1-bit full subtractor: computes a - b - bin.
//   a    in  : minuend bit
//   b    in  : subtrahend bit
//   bin  in  : borrow in
//   d    out : difference bit
//   bout out : borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when b exceeds a, or when they are equal and a borrow ripples in.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor, diff = a - b (mod 2^WIDTH), LSB first,
// one bit per clock through a single full_subtractor cell and a borrow FF.
//   clk        in  : clock, rising edge
//   rst        in  : asynchronous active-high reset
//   start      in  : load a/b and begin; sampled only in IDLE or DONE
//   a, b       in  : operands [WIDTH-1:0], captured on the accepting edge
//   busy       out : high while shifting
//   done       out : one-cycle pulse, result valid
//   diff       out : result register [WIDTH-1:0]
//   borrow_out out : final borrow (a < b unsigned)
//   overflow   out : signed overflow flag
// Build option: define SERIAL_SUB_OVERFLOW_EN to compute overflow from the
// captured operand MSBs; otherwise overflow is tied low.
// ---------------------------------------------------------------------------
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sr_reg, b_sr_reg;
   logic [WIDTH-1:0] a_sr_next, b_sr_next;
   // Only WIDTH-1 partial bits need storing: the final bit goes straight
   // from the cell into the result register on the last edge.
   logic [WIDTH-2:0] part_reg, part_next;
   logic [CW-1:0]    cnt_reg;
   logic             brw_reg, brw_next;
   logic             d_bit;
   logic [WIDTH-1:0] diff_reg;
   logic             borrow_reg;
   logic             load, shift_en, last;

   full_subtractor u_fs (
      .a    (a_sr_reg[0]),
      .b    (b_sr_reg[0]),
      .bin  (brw_reg),
      .d    (d_bit),
      .bout (brw_next)
   );

   // Right-shift networks; the new difference bit enters at the top.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_op_shift
         assign a_sr_next[gi] = a_sr_reg[gi+1];
         assign b_sr_next[gi] = b_sr_reg[gi+1];
      end
      for (gi = 0; gi < WIDTH - 2; gi++) begin : g_part_shift
         assign part_next[gi] = part_reg[gi+1];
      end
   endgenerate
   assign a_sr_next[WIDTH-1] = 1'b0;
   assign b_sr_next[WIDTH-1] = 1'b0;
   assign part_next[WIDTH-2] = d_bit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state and control
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      shift_en   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            if (cnt_reg == CNT_LAST) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign last = shift_en && (cnt_reg == CNT_LAST);

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         part_reg   <= '0;
         cnt_reg    <= '0;
         brw_reg    <= 1'b0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
      end else if (load) begin
         a_sr_reg <= a;
         b_sr_reg <= b;
         cnt_reg  <= '0;
         brw_reg  <= 1'b0;
      end else if (shift_en) begin
         a_sr_reg <= a_sr_next;
         b_sr_reg <= b_sr_next;
         part_reg <= part_next;
         brw_reg  <= brw_next;
         if (last) begin
            diff_reg   <= {d_bit, part_reg};
            borrow_reg <= brw_next;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign diff       = diff_reg;
   assign borrow_out = borrow_reg;

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic a_msb_reg, b_msb_reg, ov_reg;

   // Operand signs captured at load; d_bit on the last edge is the result MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
         ov_reg    <= 1'b0;
      end else if (load) begin
         a_msb_reg <= a[WIDTH-1];
         b_msb_reg <= b[WIDTH-1];
      end else if (last) begin
         ov_reg <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ d_bit);
      end
   end

   assign overflow = ov_reg;
`else
   assign overflow = 1'b0;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor (WIDTH=8). Expected results are
// queued when an operation is started and popped when done is observed.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             busy, done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out, overflow;

   typedef struct packed {
      logic [WIDTH-1:0] diff;
      logic             borrow;
      logic             ov;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t e;
      e.diff   = x - y;
      e.borrow = (x < y);
`ifdef SERIAL_SUB_OVERFLOW_EN
      e.ov = (x[WIDTH-1] ^ y[WIDTH-1]) & (x[WIDTH-1] ^ e.diff[WIDTH-1]);
`else
      e.ov = 1'b0;
`endif
      return e;
   endfunction

   task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      sb.push_back(model(x, y));
   endtask

   // Waits (bounded) for done; counts negedges up to and including the done one.
   task automatic wait_done(input bit drop, output int cycles, output int busy_cnt,
                            output bit first_busy, output bit timeout);
      cycles = 0; busy_cnt = 0; first_busy = 1'b0; timeout = 1'b1;
      for (int i = 0; i < 4 * WIDTH; i++) begin
         @(negedge clk);
         if (drop) start = 1'b0;
         cycles++;
         if (i == 0) first_busy = busy;
         if (done) begin
            timeout = 1'b0;
            break;
         end
         if (busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++; $display("FAIL reset_ctrl: busy/done=%b required 00", {busy, done});
      end
      n_checks++;
      if ({diff, borrow_out, overflow} !== '0) begin
         n_fail++; $display("FAIL reset_data: diff=%h borrow=%b ov=%b required 0", diff, borrow_out, overflow);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++; $display("FAIL idle_after_reset: busy/done=%b required 00", {busy, done});
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] ta[8] = '{8'h05, 8'h03, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h00, 8'h00};
      logic [WIDTH-1:0] tb_[8] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00};
      int cyc, bcnt; bit fb, to; exp_t e;
      ta[6] = 8'($urandom); tb_[6] = 8'($urandom);
      ta[7] = 8'($urandom); tb_[7] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         start_op(ta[i], tb_[i]);
         wait_done(1'b1, cyc, bcnt, fb, to);
         n_checks++;
         if (to || cyc != WIDTH + 1) begin
            n_fail++; $display("FAIL basic_latency[%0d]: %0d edges (timeout=%b) required %0d", i, cyc, to, WIDTH + 1);
         end
         n_checks++;
         if (bcnt != WIDTH) begin
            n_fail++; $display("FAIL basic_busy[%0d]: busy %0d cycles required %0d", i, bcnt, WIDTH);
         end
         e = (sb.size() > 0) ? sb.pop_front() : '0;
         n_checks++;
         if ({diff, borrow_out, overflow} !== e) begin
            n_fail++; $display("FAIL basic_result[%0d] a=%h b=%h: diff=%h borrow=%b ov=%b required %h %b %b",
                               i, ta[i], tb_[i], diff, borrow_out, overflow, e.diff, e.borrow, e.ov);
         end
         $display("op a=%h b=%h -> diff=%h borrow=%b ov=%b", ta[i], tb_[i], diff, borrow_out, overflow);
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || diff !== e.diff) begin
            n_fail++; $display("FAIL basic_pulse_hold[%0d]: done=%b diff=%h required 0 %h", i, done, diff, e.diff);
         end
      end
   endtask

   task automatic test_ignore_start();
      int cyc, bcnt, extra; bit fb, to; exp_t e;
      start_op(8'h10, 8'h10);
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 8'hFF;
      @(negedge clk); start = 1'b0;
      wait_done(1'b1, cyc, bcnt, fb, to);
      n_checks++;
      if (to || cyc != WIDTH + 1 - 4) begin
         n_fail++; $display("FAIL ignore_latency: %0d edges (timeout=%b) required %0d", cyc, to, WIDTH - 3);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if ({diff, borrow_out} !== {e.diff, e.borrow}) begin
         n_fail++; $display("FAIL ignore_result: diff=%h borrow=%b required %h %b", diff, borrow_out, e.diff, e.borrow);
      end
      $display("op a=10 b=10 (restart ignored) -> diff=%h borrow=%b", diff, borrow_out);
      extra = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++; $display("FAIL ignore_single_done: %0d extra busy/done cycles required 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt; bit fb, to; exp_t e;
      start_op(8'h00, 8'h01);
      wait_done(1'b0, cyc, bcnt, fb, to);
      n_checks++;
      if (to || cyc != WIDTH + 1) begin
         n_fail++; $display("FAIL b2b_first_latency: %0d edges (timeout=%b) required %0d", cyc, to, WIDTH + 1);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_checks++;
      if ({diff, borrow_out} !== {e.diff, e.borrow}) begin
         n_fail++; $display("FAIL b2b_first_result: diff=%h borrow=%b required %h %b", diff, borrow_out, e.diff, e.borrow);
      end
      $display("op a=00 b=01 (first) -> diff=%h borrow=%b", diff, borrow_out);
      sb.push_back(model(a, b));
      wait_done(1'b1, cyc, bcnt, fb, to);
      n_checks++;
      if (fb !== 1'b1) begin
         n_fail++; $display("FAIL b2b_no_bubble: busy=%b after DONE required 1", fb);
      end
      n_checks++;
      if (to || cyc != WIDTH + 1) begin
         n_fail++; $display("FAIL b2b_second_latency: %0d edges (timeout=%b) required %0d", cyc, to, WIDTH + 1);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_checks++;
      if ({diff, borrow_out} !== {e.diff, e.borrow}) begin
         n_fail++; $display("FAIL b2b_second_result: diff=%h borrow=%b required %h %b", diff, borrow_out, e.diff, e.borrow);
      end
      $display("op a=00 b=01 (second) -> diff=%h borrow=%b", diff, borrow_out);
   endtask

   task automatic test_reset_mid();
      int cyc, bcnt, dones; bit fb, to; exp_t e;
      start_op(8'h3C, 8'h11);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, diff, borrow_out, overflow} !== '0) begin
         n_fail++; $display("FAIL midreset_clear: busy=%b done=%b diff=%h borrow=%b ov=%b required all 0",
                            busy, done, diff, borrow_out, overflow);
      end
      void'(sb.pop_back());
      @(negedge clk); rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++; $display("FAIL midreset_no_done: %0d done pulses required 0", dones);
      end
      start_op(8'h09, 8'h04);
      wait_done(1'b1, cyc, bcnt, fb, to);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_checks++;
      if (to || {diff, borrow_out, overflow} !== e) begin
         n_fail++; $display("FAIL midreset_next: diff=%h borrow=%b ov=%b timeout=%b required %h %b %b",
                            diff, borrow_out, overflow, to, e.diff, e.borrow, e.ov);
      end
      $display("op a=09 b=04 (after reset) -> diff=%h borrow=%b", diff, borrow_out);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_subtractor
